// File: rtl/fetch_entry_queue.sv
// In-order fetch-entry buffer between I-cache responses and id_stage.
// Optional same-cycle bypass when empty: define FETCH_ENTRY_QUEUE_BYPASS_EN.
module fetch_entry_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [VLEN-1:0]          in_addr_i,
    input  logic [31:0]              in_instr_i,
    input  logic                     in_ex_i,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [VLEN-1:0]          fetch_entry_addr_o,
    output logic [31:0]              fetch_entry_instr_o,
    output logic                     fetch_entry_ex_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [VLEN-1:0] addr_q  [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [DEPTH-1:0] ex_q;

    logic [AW-1:0] rptr_q;
    logic [AW-1:0] wptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   drop_q;

    logic full;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic [16:0] drop_sum;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

`ifdef FETCH_ENTRY_QUEUE_BYPASS_EN
    assign bypass = rst_ni && empty && !flush_i
                 && in_valid_i && fetch_entry_ready_i;
`else
    assign bypass = 1'b0;
`endif

    // Ready ignores fetch_entry_ready_i so decode never reaches the I-cache.
    assign in_ready_o = rst_ni && !full && !flush_i;
    assign push = in_valid_i && in_ready_o && !bypass;

    assign fetch_entry_valid_o = rst_ni && !flush_i && (!empty || bypass);
    assign pop = fetch_entry_valid_o && fetch_entry_ready_i && !bypass;

    always_comb begin
        fetch_entry_addr_o  = '0;
        fetch_entry_instr_o = '0;
        fetch_entry_ex_o    = 1'b0;
        if (bypass) begin
            fetch_entry_addr_o  = in_addr_i;
            fetch_entry_instr_o = in_instr_i;
            fetch_entry_ex_o    = in_ex_i;
        end else if (rst_ni) begin
            fetch_entry_addr_o  = addr_q[rptr_q];
            fetch_entry_instr_o = instr_q[rptr_q];
            fetch_entry_ex_o    = ex_q[rptr_q];
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wptr_q]  <= in_addr_i;
            instr_q[wptr_q] <= in_instr_i;
            ex_q[wptr_q]    <= in_ex_i;
        end
    end

    assign drop_sum = {1'b0, drop_q} + 17'(count_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else if (flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            drop_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    assign count_o    = count_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Scoreboard bench for fetch_entry_queue: directed pushes, monitor-side pops.
// Bypass expectations follow FETCH_ENTRY_QUEUE_BYPASS_EN.
module tb_fetch_entry_queue;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] instr;
        logic        ex;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] in_addr_i = '0;
    logic [31:0] in_instr_i = '0;
    logic        in_ex_i = 1'b0;
    logic        fe_valid;
    logic        fe_ready = 1'b0;
    logic [63:0] fe_addr;
    logic [31:0] fe_instr;
    logic        fe_ex;
    logic [2:0]  count_o;
    logic [15:0] drop_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    ent_t sb[$];

    fetch_entry_queue #(.DEPTH(4), .VLEN(64)) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .flush_i(flush_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_addr_i(in_addr_i),
        .in_instr_i(in_instr_i),
        .in_ex_i(in_ex_i),
        .fetch_entry_valid_o(fe_valid),
        .fetch_entry_ready_i(fe_ready),
        .fetch_entry_addr_o(fe_addr),
        .fetch_entry_instr_o(fe_instr),
        .fetch_entry_ex_o(fe_ex),
        .count_o(count_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every handshake consumes the oldest expected entry.
    always @(negedge clk) begin
        if (rst_ni && fe_valid && fe_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got addr %h expected none",
                         fe_addr);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("pop_addr", fe_addr, e.addr);
                chk("pop_instr", {32'h0, fe_instr}, {32'h0, e.instr});
                chk("pop_ex", {63'h0, fe_ex}, {63'h0, e.ex});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_send(input logic [63:0] a, input logic [31:0] i,
                              input logic x);
        ent_t e;
        in_valid_i = 1'b1;
        in_addr_i  = a;
        in_instr_i = i;
        in_ex_i    = x;
        e.addr = a;
        e.instr = i;
        e.ex = x;
        sb.push_back(e);
    endtask

    task automatic wait_accept();
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready_o;
            cyc();
        end
        in_valid_i = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [31:0] i,
                        input logic x);
        start_send(a, i, x);
        wait_accept();
    endtask

    task automatic drain();
        fe_ready = 1'b1;
        for (int k = 0; k < 20 && (sb.size() != 0 || count_o != 0); k++)
            cyc();
        fe_ready = 1'b0;
        @(negedge clk);
        chk("drain_count", 64'(count_o), 64'd0);
        chk("drain_sb", 64'(sb.size()), 64'd0);
        cyc();
    endtask

    initial begin
        #12;
        chk("rst_valid", 64'(fe_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_addr", fe_addr, 64'd0);
        chk("rst_instr", 64'(fe_instr), 64'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        cyc();

        // Single entry
        send(64'h8000_0000, 32'h0000_0013, 1'b0);
        @(negedge clk);
        chk("single_valid", 64'(fe_valid), 64'd1);
        chk("single_count", 64'(count_o), 64'd1);
        chk("single_addr", fe_addr, 64'h8000_0000);
        chk("single_instr", 64'(fe_instr), 64'h13);
        cyc();
        fe_ready = 1'b1;
        cyc();
        fe_ready = 1'b0;
        @(negedge clk);
        chk("single_cnt0", 64'(count_o), 64'd0);
        chk("single_val0", 64'(fe_valid), 64'd0);
        cyc();

        // Fill and order, with a held-off fifth push
        send(64'h8000_1000, 32'h0000_0013, 1'b0);
        send(64'h8000_1004, 32'h0010_0093, 1'b0);
        send(64'h8000_1008, 32'h0020_0113, 1'b1);
        send(64'h8000_100c, 32'h0030_0193, 1'b0);
        @(negedge clk);
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_in_ready", 64'(in_ready_o), 64'd0);
        cyc();
        start_send(64'h8000_1010, 32'h0040_0213, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("held_in_ready", 64'(in_ready_o), 64'd0);
            chk("held_count", 64'(count_o), 64'd4);
            chk("held_head", fe_addr, 64'h8000_1000);
            cyc();
        end
        fe_ready = 1'b1;
        wait_accept();
        drain();

        // Wrap-around with a 2-entry backlog
        send(64'h8000_2000, 32'h1111_0013, 1'b0);
        send(64'h8000_2004, 32'h1111_0093, 1'b0);
        fe_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            start_send(64'h8000_2008 + 64'(4 * k),
                       32'h2000_0013 + 32'(k << 7), k[0]);
            @(negedge clk);
            chk("wrap_count", 64'(count_o), 64'd2);
            chk("wrap_in_ready", 64'(in_ready_o), 64'd1);
            cyc();
        end
        in_valid_i = 1'b0;
        drain();

        // Flush with a coincident push
        send(64'h8000_3000, 32'h3000_0013, 1'b0);
        send(64'h8000_3004, 32'h3000_0093, 1'b1);
        send(64'h8000_3008, 32'h3000_0113, 1'b0);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_addr_i  = 64'h8000_300c;
        in_instr_i = 32'h3000_0193;
        fe_ready   = 1'b1;
        @(negedge clk);
        chk("flush_valid", 64'(fe_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready_o), 64'd0);
        cyc();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        fe_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("post_flush_count", 64'(count_o), 64'd0);
        chk("post_flush_drop", 64'(drop_cnt_o), 64'd3);
        chk("post_flush_ready", 64'(in_ready_o), 64'd1);
        chk("post_flush_valid", 64'(fe_valid), 64'd0);
        cyc();

        // Asynchronous reset mid-stream
        send(64'h8000_4000, 32'h4000_0013, 1'b0);
        send(64'h8000_4004, 32'h4000_0093, 1'b0);
        @(negedge clk);
        chk("pre_rst_count", 64'(count_o), 64'd2);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(fe_valid), 64'd0);
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_drop", 64'(drop_cnt_o), 64'd0);
        chk("arst_in_ready", 64'(in_ready_o), 64'd0);
        sb.delete();
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Empty queue, push with decode ready
        fe_ready = 1'b1;
        start_send(64'h8000_0100, 32'h0000_006f, 1'b0);
        @(negedge clk);
`ifdef FETCH_ENTRY_QUEUE_BYPASS_EN
        chk("byp_valid", 64'(fe_valid), 64'd1);
        chk("byp_instr", 64'(fe_instr), 64'h6f);
        chk("byp_count", 64'(count_o), 64'd0);
        cyc();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("byp_after_count", 64'(count_o), 64'd0);
        chk("byp_after_valid", 64'(fe_valid), 64'd0);
`else
        chk("nobyp_valid", 64'(fe_valid), 64'd0);
        chk("nobyp_count", 64'(count_o), 64'd0);
        cyc();
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("nobyp_late_valid", 64'(fe_valid), 64'd1);
        chk("nobyp_late_instr", 64'(fe_instr), 64'h6f);
        chk("nobyp_late_count", 64'(count_o), 64'd1);
        cyc();
        @(negedge clk);
        chk("nobyp_end_count", 64'(count_o), 64'd0);
`endif
        cyc();
        fe_ready = 1'b0;
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_entry_queue.md
Name: fetch_entry_queue

Overview:
- Frontend-side producer of the fetch-entry valid/ready interface that feeds id_stage (fetch_entry_o / fetch_entry_valid_o / fetch_entry_ready_i).
- Buffers instruction words returned by the I-cache, each with its PC and a fetch-exception flag.
- Presents entries to decode strictly in order.
- Supports a single-cycle flush on mispredict, exception or fence.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- VLEN, 64, PC width in bits.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all buffered entries and any push in the same cycle.
- in_valid_i  in  1  I-cache response valid.
- in_ready_o  out  1  queue can accept an entry.
- in_addr_i  in  VLEN  PC of the instruction.
- in_instr_i  in  32  instruction word.
- in_ex_i  in  1  fetch exception (page fault / access fault) for this entry.
- fetch_entry_valid_o  out  1  head entry valid towards id_stage.
- fetch_entry_ready_i  in  1  id_stage accepts the head entry.
- fetch_entry_addr_o  out  VLEN  head PC.
- fetch_entry_instr_o  out  32  head instruction.
- fetch_entry_ex_o  out  1  head exception flag.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt_o  out  16  number of entries discarded by flush; saturating.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - read and write pointers = 0, count = 0, drop_cnt = 0.
  - fetch_entry_valid_o = 0, in_ready_o = 0 while in reset, data outputs = 0.
  - Storage array is not reset.
- Structure: circular buffer with wrapping read/write pointers of width $clog2(DEPTH) and a separate count of width $clog2(DEPTH)+1.
  - full: count == DEPTH.
  - empty: count == 0.
- in_ready_o = !full && !flush_i. Deliberately does not depend on fetch_entry_ready_i, so there is no combinational path from decode back to the I-cache.
- push = in_valid_i && in_ready_o.
  - Writes entry at wptr; wptr increments modulo DEPTH.
- pop = fetch_entry_valid_o && fetch_entry_ready_i.
  - rptr increments modulo DEPTH.
- fetch_entry_valid_o = !empty && !flush_i. Data outputs always show the entry at rptr.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1 (without the optional feature).
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Push while full: not possible, because in_ready_o = 0. The producer must hold in_valid_i and data stable until accepted.
- Pop while empty: not possible, because fetch_entry_valid_o = 0.
- Output stability: while fetch_entry_valid_o = 1 and fetch_entry_ready_i = 0, the head entry is held stable.
- Flush (flush_i = 1):
  - In that cycle, no push and no pop take effect.
  - On the next edge, count = 0, rptr = wptr = 0.
  - drop_cnt_o += count, saturating at 0xFFFF.
  - In the cycle after the flush, the queue is empty and ready.
- Flush together with in_valid_i: the incoming entry is discarded and is not counted in drop_cnt_o.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial entries survive.
- count_o is registered and reflects state after the last edge.

Optional Feature:
- Macro: FETCH_ENTRY_QUEUE_BYPASS_EN.
- Defined:
  - When empty, flush_i = 0, in_valid_i = 1 and fetch_entry_ready_i = 1, the input passes combinationally to the fetch_entry_* outputs. fetch_entry_valid_o = 1 in the same cycle.
  - The entry is consumed without being written; count stays 0.
  - When empty and not bypassing (fetch_entry_ready_i = 0), a push is stored normally.
- Undefined:
  - No combinational in-to-out path.
  - Minimum latency of 1 cycle, as in Behaviour.

Test Plan:
- Single entry: release reset, push addr=0x80000000, instr=0x00000013, ex=0 with fetch_entry_ready_i=0 -> next cycle fetch_entry_valid_o=1, outputs match, count_o=1. Raise ready -> popped, count_o=0, valid=0 next cycle.
- Fill and order: push 0x00000013, 0x00100093, 0x00200113, 0x00300193 at consecutive PCs (+4) with ready=0 -> count_o=4, in_ready_o=0, a 5th push is held off. Then ready=1 for 4 cycles -> entries emerge in push order, ex flags intact.
- Wrap-around: sustained push and pop for 10 cycles with a 2-entry backlog -> count_o stays 2, output sequence equals input sequence, pointers wrap with no loss.
- Flush: 3 entries buffered, flush_i=1 with in_valid_i=1 -> valid=0 and in_ready_o=0 in that cycle; next cycle count_o=0 and drop_cnt_o=3.
- Async reset mid-stream: assert rst_ni low between edges with 2 entries buffered -> fetch_entry_valid_o=0 and count_o=0 immediately, drop_cnt_o=0.
- Bypass (FETCH_ENTRY_QUEUE_BYPASS_EN defined): queue empty, in_valid_i=1 and fetch_entry_ready_i=1, instr=0x0000006f -> fetch_entry_valid_o=1 and fetch_entry_instr_o=0x0000006f in the same cycle, count_o stays 0. Macro undefined -> output appears one cycle later.
